fifo_async: RTL and testbench
=============================

FIFO_ASYNC -- requirements
Module: fifo_async

Interface
REQ-001 The block SHALL have exactly one clock; its reset SHALL be asynchronous and active-low.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of storage entries (power of two, >= 2).
REQ-003 Parameter DATA_WIDTH, default 8, SHALL set the data word width in bits.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-006 wr_en  input  1  write request; data_in is stored on the rising edge when accepted.
REQ-007 rd_en  input  1  read request; the oldest entry is popped on the rising edge when accepted.
REQ-008 data_in  input  DATA_WIDTH  write data.
REQ-009 data_out  output  DATA_WIDTH  registered read data.
REQ-010 full  output  1  high when DEPTH entries are stored.
REQ-011 empty  output  1  high when 0 entries are stored.

Function
REQ-012 Pointers SHALL be log2(DEPTH)+1 bits wide: the low bits index storage and the MSB is a wrap bit.
REQ-013 empty SHALL equal (wr_ptr == rd_ptr); full SHALL be asserted when the index bits are equal and the wrap bits differ; both flags SHALL be combinational decodes of registered pointers.
REQ-014 A write SHALL be accepted when wr_en=1 and full=0, both sampled before the edge; it stores data_in at mem[wr_ptr index] and increments wr_ptr modulo 2*DEPTH.
REQ-015 A read SHALL be accepted when rd_en=1 and empty=0; data_out <= mem[rd_ptr index] and rd_ptr increments modulo 2*DEPTH.
REQ-016 Read latency SHALL be one clock: data_out is valid after the edge that accepts the read.
REQ-017 data_out SHALL hold its last value when no read is accepted.
REQ-018 A write while full SHALL be ignored with no state change; a read while empty SHALL be ignored with no state change and data_out held.
REQ-019 Simultaneous wr_en and rd_en, neither flag set: both SHALL occur and the occupancy is unchanged.
REQ-020 Simultaneous wr_en and rd_en while empty: only the write SHALL occur; the new word is not bypassed to data_out.
REQ-021 Simultaneous wr_en and rd_en while full: only the read SHALL occur.
REQ-022 Data SHALL be returned in strict write order across pointer wrap-around.

Reset
REQ-023 While rst=0, wr_ptr, rd_ptr and data_out SHALL be 0, empty SHALL be 1 and full SHALL be 0, independent of clk.
REQ-024 Reset asserted mid-operation SHALL discard all stored entries; storage contents need not be cleared.
REQ-025 wr_en and rd_en SHALL be ignored on edges where rst=0.

Structure
REQ-026 Address width (log2 DEPTH) and pointer width SHALL be derived localparams; no shared package is required.
REQ-027 The block SHALL be a single module with an inline register-array memory; no sub-modules.

Verification
REQ-028 Reset: rst=0 with wr_en=1 -> empty=1, full=0, data_out=0; no write occurs.
REQ-029 Fill: after reset, write 8 words 0..7 with rd_en=0 -> full=1 after the 8th edge; a 9th write of 0xFF is ignored.
REQ-030 Drain: rd_en=1 from full -> data_out = 0,1,...,7 on successive edges; empty=1 after the 8th read; further reads hold data_out=7.
REQ-031 Wrap: write 5, read 5, then write 6 words 0xA0..0xA5 and read 6 -> data returned in order 0xA0..0xA5; flags correct throughout.
REQ-032 Simultaneous: with 3 entries stored, assert wr_en and rd_en together for 4 cycles -> occupancy stays 3, full=0, empty=0, order preserved; with the FIFO empty, assert both for 1 cycle -> occupancy becomes 1 and data_out is unchanged.
REQ-033 Mid-operation reset: with 4 entries stored, pulse rst=0 asynchronously between edges -> empty=1 immediately, and the next read after release is ignored.

Source files
------------

// File: rtl/fifo_async_pkg.sv
// Shared helpers for the single-clock FIFO: geometry derivation.
package fifo_async_pkg;

   // Index width for a power-of-two entry count; never below one bit.
   function automatic int unsigned addr_bits(input int unsigned depth);
      int unsigned bits;
      bits = 0;
      for (int unsigned i = 1; i < depth; i = i * 2) begin
         bits = bits + 1;
      end
      if (bits == 0) begin
         bits = 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/fifo_async.sv
// Single-clock FIFO with inline register-array storage and wrap-bit pointers.
// The reset is asynchronous and active-low; storage contents are not cleared.
module fifo_async
   import fifo_async_pkg::*;
#(
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty
);

   localparam int unsigned AW = addr_bits(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;

   // Status flags decoded from the registered pointers only.
   always_comb begin
      empty  = (wr_ptr == rd_ptr);
      full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
      wr_acc = wr_en && !full;
      rd_acc = rd_en && !empty;
   end

   // Pointer and read-data registers; natural PW-bit overflow gives modulo 2*DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         data_out <= '0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_acc) begin
            data_out <= mem[rd_ptr[AW-1:0]];
            rd_ptr   <= rd_ptr + 1'b1;
         end
      end
   end

   // Storage write port; kept out of the reset domain, so rst gates it explicitly.
   always_ff @(posedge clk) begin
      if (rst && wr_acc) begin
         mem[wr_ptr[AW-1:0]] <= data_in;
      end
   end

endmodule

// File: tb/tb_fifo_async.sv
// Self-checking bench for fifo_async using a queue scoreboard.
module tb_fifo_async;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic       rd_en;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       full;
   logic       empty;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] sb [$];
   logic [7:0] exp_dout;

   fifo_async #(.DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .rd_en    (rd_en),
      .data_in  (data_in),
      .data_out (data_out),
      .full     (full),
      .empty    (empty)
   );

   always #5 clk = ~clk;

   // Drive one cycle, updating the scoreboard from its own occupancy; returns #1 after the edge.
   task automatic step(input logic we, input logic re, input logic [7:0] d);
      bit w;
      bit r;
      w = we && (sb.size() < DEPTH);
      r = re && (sb.size() > 0);
      wr_en   = we;
      rd_en   = re;
      data_in = d;
      if (r) exp_dout = sb.pop_front();
      if (w) sb.push_back(d);
      @(posedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0; wr_en = 1'b1; rd_en = 1'b0; data_in = 8'h55;
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if ({data_out, full, empty} !== {8'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_hold got dout=%h full=%b empty=%b want dout=00 full=0 empty=1", data_out, full, empty);
      end
      rst = 1'b1; wr_en = 1'b0;
      sb.delete(); exp_dout = 8'h00;
      step(1'b0, 1'b0, 8'h00);
      checks++;
      if ({data_out, full, empty} !== {8'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_nowrite got dout=%h full=%b empty=%b want dout=00 full=0 empty=1", data_out, full, empty);
      end
   endtask

   task automatic test_fill;
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 1'b0, 8'(i));
         checks++;
         if ({full, empty} !== {(i == DEPTH - 1), 1'b0}) begin
            errors++;
            $display("FAIL fill_%0d got full=%b empty=%b want full=%b empty=0", i, full, empty, (i == DEPTH - 1));
         end
      end
      step(1'b1, 1'b0, 8'hFF);
      checks++;
      if ({full, empty, data_out} !== {1'b1, 1'b0, 8'h00} || sb.size() != DEPTH) begin
         errors++;
         $display("FAIL fill_overflow got full=%b empty=%b dout=%h want full=1 empty=0 dout=00", full, empty, data_out);
      end
   endtask

   task automatic test_drain;
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, 1'b1, 8'h00);
         checks++;
         if ({data_out, full, empty} !== {exp_dout, 1'b0, (i == DEPTH - 1)} || exp_dout !== 8'(i)) begin
            errors++;
            $display("FAIL drain_%0d got dout=%h full=%b empty=%b want dout=%h full=0 empty=%b", i, data_out, full, empty, 8'(i), (i == DEPTH - 1));
         end
      end
      for (int i = 0; i < 2; i++) begin
         step(1'b0, 1'b1, 8'h00);
         checks++;
         if ({data_out, full, empty} !== {8'h07, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL drain_empty_%0d got dout=%h empty=%b want dout=07 empty=1", i, data_out, empty);
         end
      end
   endtask

   task automatic test_wrap;
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 8'h00);
         checks++;
         if ({data_out, empty} !== {8'h10 + 8'(i), (i == 4)}) begin
            errors++;
            $display("FAIL wrap_pre_%0d got dout=%h empty=%b want dout=%h empty=%b", i, data_out, empty, 8'h10 + 8'(i), (i == 4));
         end
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 1'b0, 8'hA0 + 8'(i));
         checks++;
         if ({full, empty} !== 2'b00) begin
            errors++;
            $display("FAIL wrap_wr_%0d got full=%b empty=%b want full=0 empty=0", i, full, empty);
         end
      end
      for (int i = 0; i < 6; i++) begin
         step(1'b0, 1'b1, 8'h00);
         checks++;
         if ({data_out, full, empty} !== {exp_dout, 1'b0, (i == 5)} || exp_dout !== 8'hA0 + 8'(i)) begin
            errors++;
            $display("FAIL wrap_rd_%0d got dout=%h empty=%b want dout=%h empty=%b", i, data_out, empty, 8'hA0 + 8'(i), (i == 5));
         end
      end
   endtask

   task automatic test_full_both;
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i));
      step(1'b1, 1'b1, 8'hEE);
      checks++;
      if ({data_out, full, empty} !== {8'hC0, 1'b0, 1'b0} || sb.size() != DEPTH - 1) begin
         errors++;
         $display("FAIL full_both got dout=%h full=%b empty=%b want dout=c0 full=0 empty=0", data_out, full, empty);
      end
      for (int i = 1; i < DEPTH; i++) begin
         step(1'b0, 1'b1, 8'h00);
         checks++;
         if ({data_out, empty} !== {8'hC0 + 8'(i), (i == DEPTH - 1)}) begin
            errors++;
            $display("FAIL full_both_drain_%0d got dout=%h empty=%b want dout=%h empty=%b", i, data_out, empty, 8'hC0 + 8'(i), (i == DEPTH - 1));
         end
      end
   endtask

   task automatic test_simultaneous;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h30 + 8'(i));
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b1, 8'h40 + 8'(i));
         checks++;
         if ({data_out, full, empty} !== {exp_dout, 1'b0, 1'b0} || sb.size() != 3) begin
            errors++;
            $display("FAIL simul_%0d got dout=%h full=%b empty=%b want dout=%h full=0 empty=0", i, data_out, full, empty, exp_dout);
         end
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 8'h00);
         checks++;
         if ({data_out, empty} !== {exp_dout, (i == 2)} || exp_dout !== 8'h41 + 8'(i)) begin
            errors++;
            $display("FAIL simul_drain_%0d got dout=%h empty=%b want dout=%h empty=%b", i, data_out, empty, 8'h41 + 8'(i), (i == 2));
         end
      end
      step(1'b1, 1'b1, 8'h77);
      checks++;
      if ({data_out, full, empty} !== {8'h43, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL simul_empty got dout=%h full=%b empty=%b want dout=43 full=0 empty=0", data_out, full, empty);
      end
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if ({data_out, empty} !== {8'h77, 1'b1}) begin
         errors++;
         $display("FAIL simul_empty_rd got dout=%h empty=%b want dout=77 empty=1", data_out, empty);
      end
   endtask

   task automatic test_mid_reset;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h50 + 8'(i));
      #3 rst = 1'b0;
      #1;
      checks++;
      if ({data_out, full, empty} !== {8'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL midreset_async got dout=%h full=%b empty=%b want dout=00 full=0 empty=1", data_out, full, empty);
      end
      #2 rst = 1'b1;
      sb.delete(); exp_dout = 8'h00;
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if ({data_out, full, empty} !== {8'h00, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL midreset_rd got dout=%h full=%b empty=%b want dout=00 full=0 empty=1", data_out, full, empty);
      end
      step(1'b1, 1'b0, 8'h99);
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if ({data_out, empty} !== {8'h99, 1'b1}) begin
         errors++;
         $display("FAIL midreset_recover got dout=%h empty=%b want dout=99 empty=1", data_out, empty);
      end
   endtask

   initial begin
      wr_en = 1'b0; rd_en = 1'b0; data_in = '0; rst = 1'b0; exp_dout = '0;
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_full_both();
      test_simultaneous();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
